// File: rtl/tpu_ctrl_pkg.sv
// tpu_ctrl_pkg: shared widths, command/ack bit indices, state encoding and helpers
package tpu_ctrl_pkg;
  localparam int BLK_DIM    = 4;
  localparam int TIMEOUT    = 64;
  localparam int TMO_W      = 7;
  localparam int DIM_W      = 4;
  localparam int CMD_FLAG_W = 7;
  localparam int INT_FLAG_W = 7;
  localparam int LOC_CNT_W  = 3;
  localparam int GLB_CNT_W  = 3;
  localparam int STATE_W    = 4;
  localparam int CMD_WAIT   = 0;
  localparam int CMD_BLK_A  = 1;
  localparam int CMD_BLK_B  = 2;
  localparam int CMD_READ_A = 3;
  localparam int CMD_READ_B = 4;
  localparam int CMD_FEED   = 5;
  localparam int CMD_WRIT   = 6;
  localparam int INT_WAIT   = 0;
  localparam int INT_BLK_A  = 1;
  localparam int INT_BLK_B  = 2;
  localparam int INT_READ_A = 3;
  localparam int INT_READ_B = 4;
  localparam int INT_FEED   = 5;
  localparam int INT_WRIT   = 6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE, S_WAIT, S_BLK_A, S_BLK_B, S_READ_A, S_READ_B, S_FEED, S_WRIT, S_DONE
  } state_t;

  // number of BLK_DIM tiles needed to cover a dimension
  function automatic logic [GLB_CNT_W-1:0] blk_cnt(input logic [DIM_W-1:0] d);
    logic [DIM_W:0] s;
    s = {1'b0, d} + (DIM_W+1)'(BLK_DIM - 1);
    return GLB_CNT_W'(s >> $clog2(BLK_DIM));
  endfunction

  // one-hot command presented to dp while in a state
  function automatic logic [CMD_FLAG_W-1:0] cmd_of(input state_t s);
    logic [CMD_FLAG_W-1:0] c;
    c = '0;
    case (s)
      S_WAIT:   c[CMD_WAIT]   = 1'b1;
      S_BLK_A:  c[CMD_BLK_A]  = 1'b1;
      S_BLK_B:  c[CMD_BLK_B]  = 1'b1;
      S_READ_A: c[CMD_READ_A] = 1'b1;
      S_READ_B: c[CMD_READ_B] = 1'b1;
      S_FEED:   c[CMD_FEED]   = 1'b1;
      S_WRIT:   c[CMD_WRIT]   = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // dp completion flag that acknowledges a state
  function automatic logic [INT_FLAG_W-1:0] ack_of(input state_t s);
    logic [INT_FLAG_W-1:0] f;
    f = '0;
    case (s)
      S_WAIT:   f[INT_WAIT]   = 1'b1;
      S_BLK_A:  f[INT_BLK_A]  = 1'b1;
      S_BLK_B:  f[INT_BLK_B]  = 1'b1;
      S_READ_A: f[INT_READ_A] = 1'b1;
      S_READ_B: f[INT_READ_B] = 1'b1;
      S_FEED:   f[INT_FEED]   = 1'b1;
      S_WRIT:   f[INT_WRIT]   = 1'b1;
      default:  f = '0;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/tpu_ctrl_wdog.sv
// ctrl_wdog: per-state watchdog, expires after TIMEOUT cycles without a clear
module ctrl_wdog #(
  parameter int TMO_W   = 7,
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [TMO_W-1:0] r_cnt;

  // counts cycles spent in the current state; any state change restarts it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + TMO_W'(1);

  assign o_expired = i_en && (r_cnt == TMO_W'(TIMEOUT - 1));
endmodule

// File: rtl/tpu_ctrl.sv
// tpu_ctrl: tile sequencer walking C = A x B in 4x4 tiles and commanding dp
module tpu_ctrl
  import tpu_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DIM_W-1:0]      i_m,
  input  logic [DIM_W-1:0]      i_n,
  input  logic [DIM_W-1:0]      i_k,
  input  logic [INT_FLAG_W-1:0] i_int_flags,
  output logic [CMD_FLAG_W-1:0] o_cmd_flags,
  output logic                  o_cnt_rst,
  output logic [LOC_CNT_W-1:0]  o_blk_local_idx,
  output logic [GLB_CNT_W-1:0]  o_a_blk_idx,
  output logic [GLB_CNT_W-1:0]  o_b_blk_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  state_t                r_state, w_nxt;
  logic                  r_first;
  logic [GLB_CNT_W-1:0]  r_mb, r_nb, r_kb;
  logic [GLB_CNT_W-1:0]  r_a, r_b;
  logic [LOC_CNT_W-1:0]  r_loc;
  logic [CMD_FLAG_W-1:0] r_cmd;
  logic                  r_busy, r_done, r_err;
  logic                  w_ack, w_tmo, w_take, w_zero, w_expired;

  ctrl_wdog #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_take),
    .i_en      (r_state != S_IDLE),
    .o_expired (w_expired)
  );

  // a flag seen in the first cycle of a state may be left over from the previous command
  assign w_ack  = !r_first && |(i_int_flags & ack_of(r_state));
  assign w_tmo  = w_expired && !w_ack;
  assign w_zero = (r_mb == '0) || (r_nb == '0) || (r_kb == '0);
  assign w_take = w_nxt != r_state;

  // next state from the current state, its ack and the tile counters
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:            w_nxt = i_start ? S_WAIT : S_IDLE;
      S_WAIT:            if (w_ack) w_nxt = w_zero ? S_DONE : S_BLK_A;
      S_BLK_A, S_BLK_B:  if (w_ack) w_nxt = S_READ_A;
      S_READ_A:          if (w_ack) w_nxt = S_READ_B;
      S_READ_B:          if (w_ack) w_nxt = S_FEED;
      S_FEED:            if (w_ack) w_nxt = (GLB_CNT_W'(r_loc) < r_kb) ? S_READ_A : S_WRIT;
      S_WRIT:            if (w_ack) w_nxt = (r_b + GLB_CNT_W'(1) < r_nb) ? S_BLK_B :
                                            (r_a + GLB_CNT_W'(1) < r_mb) ? S_BLK_A : S_DONE;
      S_DONE:            w_nxt = S_IDLE;
      default:           w_nxt = S_IDLE;
    endcase
    if (w_tmo) w_nxt = S_IDLE;
  end

  // state, registered outputs and tile indices all move on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
      r_cmd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_mb    <= '0;
      r_nb    <= '0;
      r_kb    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_loc   <= '0;
    end else begin
      r_state <= w_nxt;
      r_first <= w_take;
      r_cmd   <= cmd_of(w_nxt);
      r_busy  <= w_nxt != S_IDLE;
      r_done  <= w_nxt == S_DONE;
      if (r_state == S_IDLE && i_start) begin
        r_mb  <= blk_cnt(i_m);
        r_nb  <= blk_cnt(i_n);
        r_kb  <= blk_cnt(i_k);
        r_err <= 1'b0;
      end
      if (w_tmo) r_err <= 1'b1;
      if (r_state == S_WAIT && w_nxt == S_BLK_A) begin
        r_a   <= '0;
        r_b   <= '0;
        r_loc <= '0;
      end
      if (r_state == S_READ_A && w_nxt == S_READ_B) r_loc <= r_loc + LOC_CNT_W'(1);
      if (r_state == S_WRIT && w_nxt == S_BLK_B) begin
        r_b   <= r_b + GLB_CNT_W'(1);
        r_loc <= '0;
      end
      if (r_state == S_WRIT && w_nxt == S_BLK_A) begin
        r_a   <= r_a + GLB_CNT_W'(1);
        r_b   <= '0;
        r_loc <= '0;
      end
    end
  end

  assign o_cmd_flags     = r_cmd;
  assign o_cnt_rst       = w_take;
  assign o_blk_local_idx = r_loc;
  assign o_a_blk_idx     = r_a;
  assign o_b_blk_idx     = r_b;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
endmodule
